rf_cmd_master: RTL and testbench

- Command-driven initiator for the team's small register file (1 write port, 2 combinational read ports, write on rising clk edge when write enable is high).
- Accepts host commands on a valid/ready channel and sequences the register-file port signals.
- Returns read results, or the computed result, on a valid/ready response channel.
- Sits between a host/test sequencer and the register file, replacing hand-driven port stimulus.

---
 rtl/rf_cmd_master.sv | 164 ++++++++++++++++
 tb/tb_rf_cmd_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_cmd_master.sv
// Command-driven initiator for the small register file: accepts host commands,
// drives the register-file ports for one cycle, then presents a response.
module rf_cmd_master #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              rsp_err,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [ADDR_W-1:0] rf_ra1,
    output logic [ADDR_W-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] src2_q, src2_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
    logic [DATA_W-1:0] rsp_data2_q, rsp_data2_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic              in_exec;
    logic              writes_rf;
    logic [DATA_W-1:0] sum;

    assign in_exec   = (state_q == EXEC);
    assign writes_rf = (op_q == OP_WRITE) || (op_q == OP_ADD);
    // Carry is dropped; operands are the pre-write values since reads are combinational.
    assign sum       = rf_rd1 + rf_rd2;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    src1_d  = cmd_src1;
                    src2_d  = cmd_src2;
                    data_d  = cmd_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data2_d = '0;
                case (op_q)
                    OP_WRITE: rsp_data1_d = data_q;
                    OP_READ: begin
                        rsp_data1_d = rf_rd1;
                        rsp_data2_d = rf_rd2;
                    end
                    OP_ADD:   rsp_data1_d = sum;
                    default: begin
                        rsp_data1_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                endcase
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            dst_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            data_q      <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            data_q      <= data_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
        end
    end

    // Reset gates the write enable directly so an abandoned EXEC never lands a write.
    assign rf_we  = in_exec && writes_rf && !reset;
    assign rf_wa  = (in_exec && writes_rf) ? dst_q : '0;
    assign rf_wd  = !in_exec ? '0 : (op_q == OP_ADD) ? sum : (op_q == OP_WRITE) ? data_q : '0;
    assign rf_ra1 = in_exec ? src1_q : '0;
    assign rf_ra2 = in_exec ? src2_q : '0;

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data1 = rsp_data1_q;
    assign rsp_data2 = rsp_data2_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_rf_cmd_master.sv
// Scoreboard bench for rf_cmd_master with a small register file attached and a
// behavioural model that predicts responses and writes at command issue.
module tb_rf_cmd_master;

    localparam int DATA_W = 2;
    localparam int ADDR_W = 1;
    localparam int CNT_W  = 8;
    localparam int NREGS  = 2 ** ADDR_W;
    localparam int DMOD   = 2 ** DATA_W;
    localparam int CMOD   = 2 ** CNT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_dst, cmd_src1, cmd_src2;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data1, rsp_data2;
    logic              rsp_err;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa, rf_ra1, rf_ra2;
    logic [DATA_W-1:0] rf_wd, rf_rd1, rf_rd2;
    logic [CNT_W-1:0]  op_count;

    always #5 clk = ~clk;

    rf_cmd_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data1(rsp_data1),
        .rsp_data2(rsp_data2), .rsp_err(rsp_err),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .op_count(op_count)
    );

    // Register file the DUT drives: synchronous write, combinational reads.
    logic [DATA_W-1:0] rf_mem [NREGS];
    logic              mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < NREGS; i++) rf_mem[i] <= '0;
        end else if (rf_we) begin
            rf_mem[rf_wa] <= rf_wd;
        end
    end

    assign rf_rd1 = rf_mem[rf_ra1];
    assign rf_rd2 = rf_mem[rf_ra2];

    typedef struct {
        int d1;
        int d2;
        int err;
    } rsp_t;

    typedef struct {
        int wa;
        int wd;
    } wr_t;

    rsp_t exp_q[$];
    wr_t  wr_q[$];
    int   model_mem [NREGS];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 2;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Predicts the response and any register write, then drives the command until accepted.
    task automatic applyStimulus(input int op, input int dst, input int s1, input int s2,
                                 input int data, input bit abort);
        int   waited;
        rsp_t r;
        wr_t  w;
        @(negedge clk);
        cmd_op    = 2'(op);
        cmd_dst   = ADDR_W'(dst);
        cmd_src1  = ADDR_W'(s1);
        cmd_src2  = ADDR_W'(s2);
        cmd_data  = DATA_W'(data);
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        if (!abort) begin
            r.d2  = 0;
            r.err = 0;
            case (op)
                0: begin
                    model_mem[dst] = data;
                    r.d1 = data;
                    w.wa = dst; w.wd = data; wr_q.push_back(w);
                end
                1: begin
                    r.d1 = model_mem[s1];
                    r.d2 = model_mem[s2];
                end
                2: begin
                    r.d1 = (model_mem[s1] + model_mem[s2]) % DMOD;
                    model_mem[dst] = r.d1;
                    w.wa = dst; w.wd = r.d1; wr_q.push_back(w);
                end
                default: begin
                    r.d1  = 0;
                    r.err = 1;
                end
            endcase
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        if (abort) begin
            reset = 1'b1;
            @(negedge clk);
            checkOutput("we_gated_by_reset", rf_we, 0);
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(negedge clk);
            checkOutput("abort_rsp_valid", rsp_valid, 0);
            checkOutput("abort_op_count", op_count, 0);
            checkOutput("abort_cmd_ready", cmd_ready, 0);
            @(negedge clk);
            checkOutput("abort_back_idle", cmd_ready, 1);
        end
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_timeout", exp_q.size() + wr_q.size(), 0);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'($urandom_range(0, 1));
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    // Monitor: compares writes and handshaken responses against the queued predictions.
    int   exp_count = 0;
    bit   hold = 0;
    rsp_t held;

    always @(negedge clk) begin
        rsp_t r;
        wr_t  w;
        if (reset) begin
            exp_count = 0;
            hold      = 0;
        end else begin
            if (rf_we) begin
                if (wr_q.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    checkOutput("rf_wa", 32'(rf_wa), w.wa);
                    checkOutput("rf_wd", 32'(rf_wd), w.wd);
                end
            end
            if (cmd_ready) begin
                checkOutput("rf_idle_zero", {rf_we, rf_wa, rf_wd, rf_ra1, rf_ra2}, 0);
            end
            if (rsp_valid) begin
                checkOutput("cmd_ready_in_resp", cmd_ready, 0);
                if (hold) begin
                    checkOutput("held_data1", 32'(rsp_data1), held.d1);
                    checkOutput("held_data2", 32'(rsp_data2), held.d2);
                    checkOutput("held_err", 32'(rsp_err), held.err);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_rsp", 1, 0);
                    end else begin
                        r = exp_q.pop_front();
                        checkOutput("rsp_data1", 32'(rsp_data1), r.d1);
                        checkOutput("rsp_data2", 32'(rsp_data2), r.d2);
                        checkOutput("rsp_err", 32'(rsp_err), r.err);
                        checkOutput("op_count", 32'(op_count), exp_count);
                    end
                    exp_count = (exp_count + 1) % CMOD;
                    hold = 0;
                end else begin
                    hold     = 1;
                    held.d1  = int'(rsp_data1);
                    held.d2  = int'(rsp_data2);
                    held.err = int'(rsp_err);
                end
            end else if (hold) begin
                checkOutput("rsp_valid_dropped", 0, 1);
                hold = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        mem_clear = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_dst   = '0;
        cmd_src1  = '0;
        cmd_src2  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) model_mem[i] = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs",
                    {cmd_ready, rsp_valid, rsp_data1, rsp_data2, rsp_err,
                     rf_we, rf_wa, rf_wd, rf_ra1, rf_ra2, op_count}, 0);
        reset     = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", cmd_ready, 1);
        checkOutput("count_after_reset", op_count, 0);

        rdy_mode = 2;
        applyStimulus(0, 0, 0, 0, 1, 1'b0);
        applyStimulus(0, 1, 0, 0, 3, 1'b0);
        drain();
        checkOutput("count_after_writes", op_count, 2);
        applyStimulus(1, 0, 0, 1, 0, 1'b0);
        applyStimulus(2, 0, 0, 1, 0, 1'b0);
        applyStimulus(1, 0, 0, 0, 0, 1'b0);
        applyStimulus(3, 1, 1, 0, 2, 1'b0);
        drain();
        checkOutput("err_cleared", rsp_err, 0);

        rdy_mode = 1;
        applyStimulus(1, 0, 1, 0, 0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("hold_valid", rsp_valid, 1);
        rdy_mode = 2;
        drain();

        applyStimulus(0, 1, 0, 0, 2, 1'b1);
        applyStimulus(1, 0, 0, 1, 0, 1'b0);
        drain();

        rdy_mode = 0;
        for (int n = 0; n < 150; n++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, NREGS - 1),
                          $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                          $urandom_range(0, DMOD - 1), 1'b0);
        end
        rdy_mode = 2;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
